// File: rtl/bv_merge_ctrl_if.sv
// Field-in / result-out bundle for the bit-vector merge stage.
// The slave modport is the merge controller; the master modport is the lookup/action side.
interface bv_merge_ctrl_if #(
  parameter int RULE_NUM  = 64,
  parameter int FIELD_NUM = 5,
  parameter int IDX_W     = 6
);
  logic [FIELD_NUM-1:0]          field_valid;
  logic [FIELD_NUM*RULE_NUM-1:0] field_bv;
  logic                          in_ready;
  logic                          bv_out_valid;
  logic [RULE_NUM-1:0]           bv_out;
  logic                          match_valid;
  logic                          match_hit;
  logic [IDX_W-1:0]              match_idx;
  logic                          out_ready;
  logic                          dup_err;

  modport slave (
    input  field_valid, field_bv, out_ready,
    output in_ready, bv_out_valid, bv_out, match_valid, match_hit, match_idx, dup_err
  );

  modport master (
    output field_valid, field_bv, out_ready,
    input  in_ready, bv_out_valid, bv_out, match_valid, match_hit, match_idx, dup_err
  );
endinterface

// File: rtl/bv_merge_ctrl.sv
// Bit-vector merge: ANDs per-field rule vectors as they arrive out of order, then
// scans the merged vector CHUNK bits per cycle for the lowest set rule index.
module bv_merge_ctrl #(
  parameter int RULE_NUM  = 64,
  parameter int FIELD_NUM = 5,
  parameter int CHUNK     = 16,
  parameter int IDX_W     = 6
) (
  input  logic           clk,
  input  logic           reset,
  bv_merge_ctrl_if.slave bus
);
  localparam int NCH = RULE_NUM / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int LW  = (CHUNK > 1) ? $clog2(CHUNK) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, SEARCH, HOLD} state_e;

  state_e                r_state;
  logic [RULE_NUM-1:0]   r_acc;
  logic [FIELD_NUM-1:0]  r_mask;
  logic [CW-1:0]         r_chunk;
  logic                  r_vld;
  logic                  r_hit;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_dup;

  logic                                 w_accept;
  logic [FIELD_NUM-1:0]                 w_new;
  logic [FIELD_NUM-1:0]                 w_mask_nxt;
  logic                                 w_dup_hit;
  logic [FIELD_NUM-1:0][RULE_NUM-1:0]   w_slice;
  logic [RULE_NUM-1:0]                  w_acc_nxt;
  logic [CHUNK-1:0]                     w_chunk;
  logic                                 w_any;
  logic [LW-1:0]                        w_lsb;
  logic [IDX_W-1:0]                     w_found_idx;

  assign w_accept   = (r_state == IDLE) || (r_state == COLLECT);
  assign w_new      = w_accept ? (bus.field_valid & ~r_mask) : '0;
  assign w_dup_hit  = w_accept && (|(bus.field_valid & r_mask));
  assign w_mask_nxt = r_mask | w_new;

  // Fields not newly arriving contribute all-ones so they drop out of the AND.
  for (genvar g = 0; g < FIELD_NUM; g++) begin : g_slice
    assign w_slice[g] = w_new[g] ? bus.field_bv[g*RULE_NUM +: RULE_NUM] : '1;
  end

  always_comb begin
    w_acc_nxt = r_acc;
    for (int i = 0; i < FIELD_NUM; i++) w_acc_nxt = w_acc_nxt & w_slice[i];
  end

  assign w_chunk = r_acc[r_chunk*CHUNK +: CHUNK];
  assign w_any   = |w_chunk;

  // Scan high to low so the lowest set bit wins.
  always_comb begin
    w_lsb = '0;
    for (int j = CHUNK-1; j >= 0; j--) begin
      if (w_chunk[j]) w_lsb = LW'(j);
    end
  end

  assign w_found_idx = IDX_W'(int'(r_chunk) * CHUNK) + IDX_W'(w_lsb);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_acc   <= '1;
      r_mask  <= '0;
      r_chunk <= '0;
      r_vld   <= 1'b0;
      r_hit   <= 1'b0;
      r_idx   <= '0;
      r_dup   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, COLLECT: begin
          if (w_dup_hit) r_dup <= 1'b1;
          if (|w_new) begin
            r_acc  <= w_acc_nxt;
            r_mask <= w_mask_nxt;
            if (&w_mask_nxt) begin
              r_state <= SEARCH;
              r_chunk <= '0;
            end else begin
              r_state <= COLLECT;
            end
          end
        end
        SEARCH: begin
          if (w_any) begin
            r_idx   <= w_found_idx;
            r_hit   <= 1'b1;
            r_vld   <= 1'b1;
            r_state <= HOLD;
          end else if (r_chunk == CW'(NCH-1)) begin
            r_idx   <= '0;
            r_hit   <= 1'b0;
            r_vld   <= 1'b1;
            r_state <= HOLD;
          end else begin
            r_chunk <= r_chunk + 1'b1;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            r_vld   <= 1'b0;
            r_acc   <= '1;
            r_mask  <= '0;
            r_chunk <= '0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Accumulator idles at all ones, so the visible vector is gated by valid.
  assign bus.in_ready     = w_accept;
  assign bus.bv_out_valid = r_vld;
  assign bus.match_valid  = r_vld;
  assign bus.bv_out       = r_vld ? r_acc : '0;
  assign bus.match_hit    = r_hit;
  assign bus.match_idx    = r_idx;
  assign bus.dup_err      = r_dup;
endmodule

// File: tb/tb_bv_merge_ctrl.sv
// Directed bench for bv_merge_ctrl: merge, priority search latency, duplicates,
// output backpressure and mid-search reset.
module tb_bv_merge_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;
  logic [63:0] fv [5];
  int   ord [5];

  bv_merge_ctrl_if bif ();
  bv_merge_ctrl dut (.clk(clk), .reset(reset), .bus(bif));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached, want finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] v);
    bif.field_valid = v;
    for (int i = 0; i < 5; i++) bif.field_bv[i*64 +: 64] = fv[i];
  endtask

  task automatic set_all(input logic [63:0] x);
    for (int i = 0; i < 5; i++) fv[i] = x;
  endtask

  // Called right after the last field was driven; edge T is the next posedge.
  task automatic wait_res(input string tag, input int lat, input logic [63:0] ebv,
                          input logic ehit, input logic [5:0] eidx);
    @(negedge clk);
    drive(5'h0);
    chk({tag, ":vld_T"}, bif.bv_out_valid, 0);
    chk({tag, ":rdy_T"}, bif.in_ready, 0);
    for (int j = 1; j < lat; j++) begin
      @(negedge clk);
      chk({tag, ":vld_early"}, bif.bv_out_valid, 0);
    end
    @(negedge clk);
    chk({tag, ":bv_vld"}, bif.bv_out_valid, 1);
    chk({tag, ":m_vld"}, bif.match_valid, 1);
    chk({tag, ":hit"}, bif.match_hit, ehit);
    chk({tag, ":idx"}, bif.match_idx, eidx);
    chk({tag, ":bv"}, bif.bv_out, ebv);
  endtask

  task automatic xfer(input string tag);
    bif.out_ready = 1'b1;
    @(negedge clk);
    bif.out_ready = 1'b0;
    chk({tag, ":xfer_vld"}, bif.bv_out_valid, 0);
    chk({tag, ":xfer_rdy"}, bif.in_ready, 1);
  endtask

  initial begin
    bif.out_ready = 1'b0;
    set_all(64'h0);
    drive(5'h0);
    repeat (2) @(negedge clk);
    chk("rst:rdy", bif.in_ready, 1);
    chk("rst:vld", bif.bv_out_valid, 0);
    chk("rst:mvld", bif.match_valid, 0);
    chk("rst:bv", bif.bv_out, 0);
    chk("rst:hit", bif.match_hit, 0);
    chk("rst:idx", bif.match_idx, 0);
    chk("rst:dup", bif.dup_err, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst:rdy", bif.in_ready, 1);

    // All fields at once, hit in chunk 1.
    set_all('1);
    fv[2] = 64'h0000_0000_0001_0000;
    drive(5'h1f);
    wait_res("t1", 2, 64'h0000_0000_0001_0000, 1'b1, 6'd16);
    xfer("t1");

    // One field per cycle, out of order, hit at bit 63.
    set_all('1);
    fv[4] = 64'h8000_0000_0000_0000;
    ord = '{4, 0, 3, 1, 2};
    for (int k = 0; k < 5; k++) begin
      chk("t2:rdy_collect", bif.in_ready, 1);
      drive(5'(1 << ord[k]));
      if (k < 4) @(negedge clk);
    end
    wait_res("t2", 4, 64'h8000_0000_0000_0000, 1'b1, 6'd63);
    xfer("t2");

    // Disjoint vectors: miss after full scan.
    set_all('1);
    fv[0] = 64'hFFFF_FFFF_0000_0000;
    fv[1] = 64'h0000_0000_FFFF_FFFF;
    drive(5'h1f);
    wait_res("t3", 4, 64'h0, 1'b0, 6'd0);
    xfer("t3");

    // Duplicate field1: second copy ignored, dup_err sticky.
    set_all('1);
    fv[1] = 64'hFF;
    drive(5'b00010);
    @(negedge clk);
    fv[1] = 64'h0;
    drive(5'b00010);
    @(negedge clk);
    chk("t4:dup", bif.dup_err, 1);
    chk("t4:rdy", bif.in_ready, 1);
    drive(5'b11101);
    wait_res("t4", 1, 64'hFF, 1'b1, 6'd0);
    xfer("t4");
    chk("t4:dup_sticky", bif.dup_err, 1);

    // Backpressure in HOLD with ignored field pulses.
    set_all('1);
    fv[3] = 64'h0000_0100_0000_0000;
    drive(5'h1f);
    wait_res("t5", 3, 64'h0000_0100_0000_0000, 1'b1, 6'd40);
    set_all(64'h0);
    for (int k = 0; k < 10; k++) begin
      drive((k % 2) ? 5'h1f : 5'h0);
      @(negedge clk);
      chk("t5:hold_vld", bif.bv_out_valid, 1);
      chk("t5:hold_bv", bif.bv_out, 64'h0000_0100_0000_0000);
      chk("t5:hold_idx", bif.match_idx, 6'd40);
      chk("t5:hold_rdy", bif.in_ready, 0);
    end
    drive(5'h0);
    xfer("t5");
    set_all('1);
    fv[0] = 64'h20;
    drive(5'h1f);
    wait_res("t5b", 1, 64'h20, 1'b1, 6'd5);
    xfer("t5b");

    // Reset mid-search, then a clean transaction.
    set_all(64'h0);
    drive(5'h1f);
    @(negedge clk);
    drive(5'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t6:rst_vld", bif.bv_out_valid, 0);
    chk("t6:rst_mvld", bif.match_valid, 0);
    chk("t6:rst_hit", bif.match_hit, 0);
    chk("t6:rst_idx", bif.match_idx, 0);
    chk("t6:rst_bv", bif.bv_out, 0);
    chk("t6:rst_dup", bif.dup_err, 0);
    chk("t6:rst_rdy", bif.in_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    set_all('1);
    fv[2] = 64'h0000_0002_0000_0000;
    drive(5'h1f);
    wait_res("t6", 3, 64'h0000_0002_0000_0000, 1'b1, 6'd33);
    xfer("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bv_merge_ctrl.md
Name: bv_merge_ctrl

Overview:
- Sequences the bit-vector merge stage of the packet classifier.
- Collects one rule bit vector per header field from the field lookup engines, which deliver out of order and on different cycles, and ANDs them into a running accumulator.
- Once all fields have arrived, scans the merged vector CHUNK bits per cycle to find the highest-priority matching rule (lowest index).
- Holds the result under a valid/ready handshake toward the action lookup stage.

Parameters:
- RULE_NUM, 64, ruleset size and bit-vector width (128/256/512/1024 also legal); must be a multiple of CHUNK.
- FIELD_NUM, 5, number of header-field bit vectors merged per packet.
- CHUNK, 16, bits examined per cycle by the priority search.
- IDX_W, 6, width of the rule index; must equal log2(RULE_NUM).

Ports:
- clk  in  1  single clock; all state on posedge.
- reset  in  1  asynchronous, active-low reset.
- field_valid  in  FIELD_NUM  bit i set = field_bv slice i valid this cycle; any combination allowed.
- field_bv  in  FIELD_NUM*RULE_NUM  packed vectors; field i at [i*RULE_NUM +: RULE_NUM].
- in_ready  out  1  fields are accepted only while high.
- bv_out_valid  out  1  merged vector valid.
- bv_out  out  RULE_NUM  merged (ANDed) vector.
- match_valid  out  1  search result valid; always asserted together with bv_out_valid.
- match_hit  out  1  1 = at least one rule matched.
- match_idx  out  IDX_W  lowest set bit index of bv_out; 0 on miss.
- out_ready  in  1  downstream accepts the result.
- dup_err  out  1  sticky; a field was presented twice in one transaction.

Behaviour:
- Reset (async, reset=0):
  - State to IDLE, accumulator to all ones, received mask to 0, chunk counter to 0.
  - bv_out, bv_out_valid, match_valid, match_hit, match_idx and dup_err all 0.
  - in_ready is 1 during and after reset.
- Reset mid-transaction abandons all partial state; the first transaction after reset starts clean.
- in_ready = 1 in IDLE and COLLECT, 0 in SEARCH and HOLD. field_valid while in_ready=0 is ignored with no side effects.
- IDLE:
  - Any field_valid bit set: acc <= acc AND every valid slice, and those bits are set in the received mask.
  - If the mask is then all ones, go to SEARCH; otherwise go to COLLECT.
- COLLECT:
  - Each cycle, every field with field_valid=1 and mask bit 0 is ANDed in and its mask bit set.
  - A field with field_valid=1 and mask bit already 1 is ignored and sets dup_err.
  - When the updated mask is all ones, go to SEARCH with the chunk counter at 0.
- SEARCH:
  - Each cycle, examine acc[c*CHUNK +: CHUNK].
  - Any bit set: match_idx <= c*CHUNK + lowest set bit, match_hit <= 1, go to HOLD.
  - No bit set: c <= c+1. If c is the last chunk (RULE_NUM/CHUNK-1), match_hit <= 0, match_idx <= 0, go to HOLD.
- HOLD:
  - bv_out = acc, with bv_out_valid = match_valid = 1.
  - All outputs stay stable while out_ready=0.
  - Transfer happens on a cycle with out_ready=1. On that edge the block goes to IDLE, clears both valids, sets acc to all ones and the mask to 0.
  - The next transaction can start the cycle after transfer.
- Latency:
  - Let edge T be the edge that accepts the last field.
  - A hit in chunk k gives valid outputs after edge T+k+1.
  - A miss gives valid outputs after edge T+RULE_NUM/CHUNK.
- Width rules:
  - All AND operations are exactly RULE_NUM bits; no padding or truncation.
  - match_idx arithmetic is unsigned in IDX_W bits.
- dup_err is cleared only by reset.

Test Plan:
- All 5 fields valid in one cycle from IDLE; field2 = 64'h0000_0000_0001_0000, others all ones -> bv_out = 64'h0000_0000_0001_0000, match_hit=1, match_idx=16, valid after edge T+2.
- Fields arrive one per cycle in order 4,0,3,1,2; AND leaves only bit 63 -> match_idx=63, match_hit=1, valid after edge T+4; in_ready=1 throughout collection.
- Two fields with disjoint vectors -> bv_out=0, match_hit=0, match_idx=0, valid after edge T+4.
- Field1 presented in cycle 1 with 64'hFF, then again in cycle 2 with 64'h0 before others arrive -> second instance ignored, dup_err=1 and stays 1, result uses 64'hFF.
- out_ready held 0 for 10 cycles in HOLD while field_valid pulses -> outputs constant, in_ready=0, pulses ignored; out_ready=1 -> valids drop next edge, in_ready=1, next transaction correct.
- reset pulsed low during SEARCH -> all outputs 0 immediately, in_ready=1; a following full transaction returns the correct idx.
